// File: rtl/bcd_serial_add_ctrl.sv
// Digit-serial packed-BCD adder sequencer. It drives one shared single-digit
// BCD adder, least-significant digit first, and returns the packed sum and
// carry-out through a valid/ready handshake.
module bcd_serial_add_ctrl #(
   parameter int unsigned DIGITS = 4,
   parameter int unsigned CNT_W  = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [4*DIGITS-1:0]   op_a,
   input  logic [4*DIGITS-1:0]   op_b,
   input  logic                  cin,
   output logic [3:0]            dig_a,
   output logic [3:0]            dig_b,
   output logic                  dig_cin,
   input  logic [3:0]            dig_sum,
   input  logic                  dig_cout,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [4*DIGITS-1:0]   result,
   output logic                  cout,
   output logic                  err
);

   localparam int unsigned W = 4 * DIGITS;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] idx;
   logic             carry;
   logic [W-1:0]     a_q;
   logic [W-1:0]     b_q;
   logic             accept;
   logic             last;

   // Flags any packed digit above 9.
   function automatic logic has_bad_digit(input logic [W-1:0] v);
      logic bad;
      bad = 1'b0;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         if (v[i*4 +: 4] > 4'd9) bad = 1'b1;
      end
      return bad;
   endfunction

   assign accept = in_valid && (state == IDLE);
   assign last   = (state == ADD) && (idx == CNT_W'(DIGITS - 1));

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state decode.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept)    state_nxt = ADD;
         ADD:     if (last)      state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default:                state_nxt = IDLE;
      endcase
   end

   // Handshake and shared-adder drive; the adder inputs are held at zero outside ADD.
   always_comb begin
      in_ready = 1'b0;
      dig_a    = 4'd0;
      dig_b    = 4'd0;
      dig_cin  = 1'b0;
      case (state)
         IDLE: in_ready = 1'b1;
         ADD: begin
            for (int unsigned i = 0; i < DIGITS; i++) begin
               if (idx == CNT_W'(i)) begin
                  dig_a = a_q[i*4 +: 4];
                  dig_b = b_q[i*4 +: 4];
               end
            end
            dig_cin = carry;
         end
         default: ;
      endcase
   end

   // Operand latch, digit walk and registered result outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx       <= '0;
         carry     <= 1'b0;
         a_q       <= '0;
         b_q       <= '0;
         result    <= '0;
         cout      <= 1'b0;
         err       <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  a_q    <= op_a;
                  b_q    <= op_b;
                  carry  <= cin;
                  idx    <= '0;
                  result <= '0;
                  err    <= has_bad_digit(op_a) | has_bad_digit(op_b);
               end
            end
            ADD: begin
               for (int unsigned i = 0; i < DIGITS; i++) begin
                  if (idx == CNT_W'(i)) result[i*4 +: 4] <= dig_sum;
               end
               carry <= dig_cout;
               if (last) begin
                  idx       <= '0;
                  cout      <= dig_cout;
                  out_valid <= 1'b1;
               end else begin
                  idx <= idx + CNT_W'(1);
               end
            end
            DONE: begin
               if (out_ready) out_valid <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule
